// File: rtl/osc_sequencer_pkg.sv
// Shared definitions for the oscillator sequencer: state encoding,
// default sizing and small state-classification helpers.
package osc_pkg;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned FREQ_W      = 16;
  localparam int unsigned COEF_W      = 32;
  localparam int unsigned MODE_W      = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    RUN       = 3'd3,
    UPD_FETCH = 3'd4,
    UPD_PULSE = 3'd5
  } osc_state_e;

  // States that hold a coefficient request open
  function automatic logic is_fetch(input osc_state_e s);
    return (s == FETCH) || (s == UPD_FETCH);
  endfunction

  // States in which the sample divider runs
  function automatic logic is_running(input osc_state_e s);
    return (s == RUN) || (s == UPD_FETCH) || (s == UPD_PULSE);
  endfunction

endpackage

// File: rtl/osc_sequencer_if.sv
// Coefficient fetch bus between the sequencer and the coefficient store.
interface osc_sequencer_if;
  import osc_pkg::*;

  logic              CoefReq;
  logic [FREQ_W-1:0] CoefAddr;
  logic              CoefAck;
  logic [COEF_W-1:0] CoefSinx;
  logic [COEF_W-1:0] CoefCos2x;

  modport master (
    output CoefReq,
    output CoefAddr,
    input  CoefAck,
    input  CoefSinx,
    input  CoefCos2x
  );

  modport slave (
    input  CoefReq,
    input  CoefAddr,
    output CoefAck,
    output CoefSinx,
    output CoefCos2x
  );

endinterface

// File: rtl/osc_sequencer_sample_tick_gen.sv
// Sample-step divider: one tick every period+1 running cycles, restarting
// from zero whenever clear is asserted.
module sample_tick_gen
  import osc_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             Fg_CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == period);

  // Count running cycles, wrapping on each tick
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/osc_sequencer.sv
// Oscillator sequencer: fetches sin/cos2 coefficients for the current
// frequency word, loads the oscillator, then paces it with Enable strobes
// while servicing frequency changes on the fly.
module osc_sequencer
  import osc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              Start,
  input  logic              Stop,
  input  logic [FREQ_W-1:0] FreqWord,
  input  logic              FreqWr,
  input  logic [MODE_W-1:0] ModeIn,
  input  logic [DIV_W-1:0]  SampleDiv,
  osc_sequencer_if.master   coef,
  output logic              Ready,
  output logic              Enable,
  output logic              FreqChng,
  output logic [COEF_W-1:0] sinx,
  output logic [COEF_W-1:0] cos2x,
  output logic [MODE_W-1:0] mode,
  output logic              Busy,
  output logic              Error
);

  localparam int unsigned     TO_W    = (TIMEOUT >= 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  osc_state_e        state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d, addr_q;
  logic              pending_q;
  logic [TO_W-1:0]   tcnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              in_fetch, freq_wr_ok, pend_set;
  logic              start_go, fetch_go, ack_take, timeout_hit;

  assign in_fetch   = is_fetch(state_q);
  assign freq_wr_ok = FreqWr && !Stop;
  assign freq_d     = freq_wr_ok ? FreqWord : freq_q;
  // A write outside RUN cannot redirect the request already in flight, so it
  // is remembered and replayed as an update fetch once RUN is reached.
  assign pend_set   = freq_wr_ok &&
                      (state_q inside {FETCH, UPD_FETCH, LOAD, UPD_PULSE});

  assign coef.CoefReq  = in_fetch;
  assign coef.CoefAddr = in_fetch ? addr_q : '0;
  assign Ready         = (state_q == LOAD);
  assign FreqChng      = (state_q == UPD_PULSE);
  assign Busy          = (state_q != IDLE);

  // State register
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes; Stop overrides everything
  always_comb begin
    state_d     = state_q;
    start_go    = 1'b0;
    fetch_go    = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = FETCH;
          start_go = 1'b1;
          fetch_go = 1'b1;
        end
      end
      FETCH, UPD_FETCH: begin
        if (coef.CoefAck) begin
          ack_take = 1'b1;
          state_d  = (state_q == FETCH) ? LOAD : UPD_PULSE;
        end else if (tcnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      LOAD:      state_d = RUN;
      RUN: begin
        if (FreqWr || pending_q) begin
          state_d  = UPD_FETCH;
          fetch_go = 1'b1;
        end
      end
      UPD_PULSE: state_d = RUN;
      default:   state_d = IDLE;
    endcase
    if (Stop) begin
      state_d     = IDLE;
      start_go    = 1'b0;
      fetch_go    = 1'b0;
      ack_take    = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  // Frequency word, latched fetch address, pending update and request timer
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      freq_q    <= '0;
      addr_q    <= '0;
      pending_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      freq_q <= freq_d;
      if (fetch_go) begin
        addr_q <= freq_d;
      end
      if (Stop || start_go || fetch_go || timeout_hit) begin
        pending_q <= 1'b0;
      end else if (pend_set) begin
        pending_q <= 1'b1;
      end
      if (fetch_go) begin
        tcnt_q <= '0;
      end else if (in_fetch) begin
        tcnt_q <= tcnt_q + TO_W'(1);
      end
    end
  end

  // Oscillator-facing held values and the sticky timeout flag
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      sinx  <= '0;
      cos2x <= '0;
      mode  <= '0;
      div_q <= '0;
      Error <= 1'b0;
    end else begin
      if (ack_take) begin
        sinx  <= coef.CoefSinx;
        cos2x <= coef.CoefCos2x;
      end
      if (start_go) begin
        mode  <= ModeIn;
        div_q <= SampleDiv;
        Error <= 1'b0;
      end else if (timeout_hit) begin
        Error <= 1'b1;
      end
    end
  end

  sample_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .Fg_CLK(Fg_CLK),
    .RESET (RESET),
    .clear (state_q == LOAD),
    .run   (is_running(state_q)),
    .period(div_q),
    .tick  (Enable)
  );

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed bench for osc_sequencer with hand-computed expectations.
module tb_osc_sequencer;

  logic        Fg_CLK = 1'b0;
  logic        RESET;
  logic        Start, Stop, FreqWr;
  logic [15:0] FreqWord;
  logic [2:0]  ModeIn;
  logic [15:0] SampleDiv;
  logic        Ready, Enable, FreqChng, Busy, Error;
  logic [31:0] sinx, cos2x;
  logic [2:0]  mode;

  osc_sequencer_if coef_bus ();

  osc_sequencer #(
    .TIMEOUT(255),
    .DIV_W  (16)
  ) dut (
    .Fg_CLK   (Fg_CLK),
    .RESET    (RESET),
    .Start    (Start),
    .Stop     (Stop),
    .FreqWord (FreqWord),
    .FreqWr   (FreqWr),
    .ModeIn   (ModeIn),
    .SampleDiv(SampleDiv),
    .coef     (coef_bus),
    .Ready    (Ready),
    .Enable   (Enable),
    .FreqChng (FreqChng),
    .sinx     (sinx),
    .cos2x    (cos2x),
    .mode     (mode),
    .Busy     (Busy),
    .Error    (Error)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   since_en = 0;
  int   div_m    = 0;
  logic en_exp   = 1'b0;
  int   n_ready, n_fchg, n_en, n_req_rise;
  logic req_prev = 1'b0;

  // Advance one cycle, sample #1 after the edge, update the cadence model
  task automatic advance();
    @(posedge Fg_CLK);
    #1;
    since_en++;
    en_exp = (since_en == div_m + 1);
    if (en_exp) since_en = 0;
    if (Ready) n_ready++;
    if (FreqChng) n_fchg++;
    if (Enable) n_en++;
    if (coef_bus.CoefReq && !req_prev) n_req_rise++;
    req_prev = coef_bus.CoefReq;
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 0; Stop = 0; FreqWr = 0; FreqWord = '0;
    ModeIn = '0; SampleDiv = '0;
    coef_bus.CoefAck = 0; coef_bus.CoefSinx = '0; coef_bus.CoefCos2x = '0;
    #2;
    n_checks++; if ({coef_bus.CoefReq, coef_bus.CoefAddr, Ready, Enable, FreqChng, sinx, cos2x, mode, Busy, Error} !== '0)
      $display("FAIL reset_outputs: got req=%b addr=%h busy=%b err=%b want all 0", coef_bus.CoefReq, coef_bus.CoefAddr, Busy, Error); else n_pass++;
    @(negedge Fg_CLK); RESET = 1'b0;
    advance();
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_start();
    FreqWord = 16'h0010; FreqWr = 1; advance(); FreqWr = 0;
    n_checks++; if (Busy !== 1'b0) $display("FAIL freqwr_idle_busy: got %b want 0", Busy); else n_pass++;
    ModeIn = 3'd5; SampleDiv = 16'd3; div_m = 3; Start = 1; advance(); Start = 0;
    n_checks++; if (coef_bus.CoefReq !== 1'b1) $display("FAIL start_req: got %b want 1", coef_bus.CoefReq); else n_pass++;
    n_checks++; if (coef_bus.CoefAddr !== 16'h0010) $display("FAIL start_addr: got %h want 0010", coef_bus.CoefAddr); else n_pass++;
    n_checks++; if (mode !== 3'd5) $display("FAIL start_mode: got %0d want 5", mode); else n_pass++;
    advance();
    n_checks++; if (coef_bus.CoefReq !== 1'b1) $display("FAIL start_req2: got %b want 1", coef_bus.CoefReq); else n_pass++;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0001; coef_bus.CoefCos2x = 32'h2222_0001;
    advance(); coef_bus.CoefAck = 0;
    n_checks++; if (Ready !== 1'b1) $display("FAIL load_ready: got %b want 1", Ready); else n_pass++;
    n_checks++; if (Enable !== 1'b0) $display("FAIL load_enable: got %b want 0", Enable); else n_pass++;
    n_checks++; if (coef_bus.CoefReq !== 1'b0) $display("FAIL load_req: got %b want 0", coef_bus.CoefReq); else n_pass++;
    n_checks++; if ({sinx, cos2x} !== {32'h1111_0001, 32'h2222_0001}) $display("FAIL load_coef: got %h/%h want 11110001/22220001", sinx, cos2x); else n_pass++;
    since_en = 0; n_ready = 0; n_en = 0;
    for (int k = 1; k <= 12; k++) begin
      advance();
      n_checks++; if (Enable !== en_exp) $display("FAIL run_cadence[%0d]: got %b want %b", k, Enable, en_exp); else n_pass++;
    end
    n_checks++; if (n_en !== 3) $display("FAIL run_en_count: got %0d want 3", n_en); else n_pass++;
    n_checks++; if (n_ready !== 0) $display("FAIL run_ready_count: got %0d want 0", n_ready); else n_pass++;
  endtask

  task automatic test_ignored();
    Start = 1; ModeIn = 3'd1; SampleDiv = 16'd7;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'hDEAD_BEEF; coef_bus.CoefCos2x = 32'hDEAD_BEEF;
    advance(); Start = 0; coef_bus.CoefAck = 0; SampleDiv = 16'd3;
    n_checks++; if (mode !== 3'd5) $display("FAIL run_start_mode: got %0d want 5", mode); else n_pass++;
    n_checks++; if (coef_bus.CoefReq !== 1'b0) $display("FAIL run_start_req: got %b want 0", coef_bus.CoefReq); else n_pass++;
    n_checks++; if (sinx !== 32'h1111_0001) $display("FAIL stray_ack_sinx: got %h want 11110001", sinx); else n_pass++;
    n_checks++; if (Enable !== en_exp) $display("FAIL ignored_cadence: got %b want %b", Enable, en_exp); else n_pass++;
    advance();
    n_checks++; if (Enable !== en_exp) $display("FAIL ignored_cadence2: got %b want %b", Enable, en_exp); else n_pass++;
  endtask

  task automatic test_update();
    n_fchg = 0;
    FreqWord = 16'h0020; FreqWr = 1; advance(); FreqWr = 0;
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if ({coef_bus.CoefReq, coef_bus.CoefAddr} !== {1'b1, 16'h0020}) $display("FAIL upd_req[%0d]: got %b/%h want 1/0020", i, coef_bus.CoefReq, coef_bus.CoefAddr); else n_pass++;
      n_checks++; if (sinx !== 32'h1111_0001) $display("FAIL upd_hold[%0d]: got %h want 11110001", i, sinx); else n_pass++;
      n_checks++; if (Enable !== en_exp) $display("FAIL upd_cadence[%0d]: got %b want %b", i, Enable, en_exp); else n_pass++;
      if (i == 5) begin
        coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0002; coef_bus.CoefCos2x = 32'h2222_0002;
      end
      advance();
    end
    coef_bus.CoefAck = 0;
    n_checks++; if (FreqChng !== 1'b1) $display("FAIL upd_fchg: got %b want 1", FreqChng); else n_pass++;
    n_checks++; if ({sinx, cos2x} !== {32'h1111_0002, 32'h2222_0002}) $display("FAIL upd_coef: got %h/%h want 11110002/22220002", sinx, cos2x); else n_pass++;
    n_checks++; if (Enable !== en_exp) $display("FAIL upd_pulse_cadence: got %b want %b", Enable, en_exp); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      advance();
      n_checks++; if (Enable !== en_exp) $display("FAIL upd_after_cadence[%0d]: got %b want %b", k, Enable, en_exp); else n_pass++;
    end
    n_checks++; if (n_fchg !== 1) $display("FAIL upd_fchg_count: got %0d want 1", n_fchg); else n_pass++;
  endtask

  task automatic test_back_to_back();
    n_fchg = 0; n_req_rise = 0;
    FreqWord = 16'h0028; FreqWr = 1; advance();
    FreqWord = 16'h0030; FreqWr = 1; advance();
    FreqWord = 16'h0040; FreqWr = 1; advance(); FreqWr = 0;
    n_checks++; if (coef_bus.CoefAddr !== 16'h0028) $display("FAIL b2b_addr_stable: got %h want 0028", coef_bus.CoefAddr); else n_pass++;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0003; coef_bus.CoefCos2x = 32'h2222_0003;
    advance(); coef_bus.CoefAck = 0;
    n_checks++; if (FreqChng !== 1'b1) $display("FAIL b2b_fchg1: got %b want 1", FreqChng); else n_pass++;
    advance();
    n_checks++; if (coef_bus.CoefReq !== 1'b0) $display("FAIL b2b_run_gap: got %b want 0", coef_bus.CoefReq); else n_pass++;
    advance();
    n_checks++; if ({coef_bus.CoefReq, coef_bus.CoefAddr} !== {1'b1, 16'h0040}) $display("FAIL b2b_followup: got %b/%h want 1/0040", coef_bus.CoefReq, coef_bus.CoefAddr); else n_pass++;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0004; coef_bus.CoefCos2x = 32'h2222_0004;
    advance(); coef_bus.CoefAck = 0;
    n_checks++; if (sinx !== 32'h1111_0004) $display("FAIL b2b_sinx: got %h want 11110004", sinx); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      advance();
      n_checks++; if (Enable !== en_exp) $display("FAIL b2b_cadence[%0d]: got %b want %b", k, Enable, en_exp); else n_pass++;
    end
    n_checks++; if (n_fchg !== 2) $display("FAIL b2b_fchg_count: got %0d want 2", n_fchg); else n_pass++;
    n_checks++; if (n_req_rise !== 2) $display("FAIL b2b_fetch_count: got %0d want 2", n_req_rise); else n_pass++;
  endtask

  task automatic test_timeout();
    int req_cycles;
    Stop = 1; advance(); Stop = 0;
    n_checks++; if (Busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", Busy); else n_pass++;
    Start = 1; ModeIn = 3'd3; SampleDiv = 16'd3; advance(); Start = 0;
    req_cycles = 0; n_ready = 0;
    for (int i = 0; i < 400; i++) begin
      if (coef_bus.CoefReq !== 1'b1) break;
      req_cycles++;
      advance();
    end
    n_checks++; if (req_cycles !== 255) $display("FAIL timeout_req_cycles: got %0d want 255", req_cycles); else n_pass++;
    n_checks++; if (Error !== 1'b1) $display("FAIL timeout_error: got %b want 1", Error); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (n_ready !== 0) $display("FAIL timeout_ready: got %0d want 0", n_ready); else n_pass++;
  endtask

  task automatic test_stop();
    ModeIn = 3'd2; SampleDiv = 16'd1; div_m = 1; Start = 1; advance(); Start = 0;
    n_checks++; if (Error !== 1'b0) $display("FAIL start_clears_error: got %b want 0", Error); else n_pass++;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0005; coef_bus.CoefCos2x = 32'h2222_0005;
    advance(); coef_bus.CoefAck = 0;
    n_checks++; if (Ready !== 1'b1) $display("FAIL stop_pre_ready: got %b want 1", Ready); else n_pass++;
    since_en = 0;
    for (int k = 1; k <= 4; k++) begin
      advance();
      n_checks++; if (Enable !== en_exp) $display("FAIL div1_cadence[%0d]: got %b want %b", k, Enable, en_exp); else n_pass++;
    end
    FreqWord = 16'h0060; FreqWr = 1; advance(); FreqWr = 0;
    n_checks++; if (coef_bus.CoefReq !== 1'b1) $display("FAIL stop_pre_req: got %b want 1", coef_bus.CoefReq); else n_pass++;
    n_ready = 0; n_fchg = 0; n_en = 0;
    Stop = 1; FreqWr = 1; FreqWord = 16'h0070;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0006; coef_bus.CoefCos2x = 32'h2222_0006;
    advance(); Stop = 0; FreqWr = 0; coef_bus.CoefAck = 0;
    n_checks++; if ({Busy, coef_bus.CoefReq, Enable} !== 3'b000) $display("FAIL stop_idle: got busy/req/en=%b%b%b want 000", Busy, coef_bus.CoefReq, Enable); else n_pass++;
    for (int k = 1; k <= 8; k++) advance();
    n_checks++; if ({n_ready, n_fchg, n_en} !== {32'd0, 32'd0, 32'd0}) $display("FAIL stop_quiet: got ready=%0d fchg=%0d en=%0d want 0/0/0", n_ready, n_fchg, n_en); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL stop_stays_idle: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_reset_run();
    ModeIn = 3'd4; SampleDiv = 16'd0; div_m = 0; Start = 1; advance(); Start = 0;
    coef_bus.CoefAck = 1; coef_bus.CoefSinx = 32'h1111_0007; coef_bus.CoefCos2x = 32'h2222_0007;
    advance(); coef_bus.CoefAck = 0;
    advance();
    n_checks++; if (Enable !== 1'b1) $display("FAIL div0_en1: got %b want 1", Enable); else n_pass++;
    advance();
    n_checks++; if (Enable !== 1'b1) $display("FAIL div0_en2: got %b want 1", Enable); else n_pass++;
    #3 RESET = 1'b1;
    #1;
    n_checks++; if ({coef_bus.CoefReq, coef_bus.CoefAddr, Ready, Enable, FreqChng, sinx, cos2x, mode, Busy, Error} !== '0)
      $display("FAIL async_reset_run: got en=%b busy=%b sinx=%h mode=%0d want all 0", Enable, Busy, sinx, mode); else n_pass++;
    @(negedge Fg_CLK); RESET = 1'b0;
    advance();
    ModeIn = 3'd6; Start = 1; advance(); Start = 0;
    n_checks++; if ({coef_bus.CoefReq, coef_bus.CoefAddr} !== {1'b1, 16'h0000}) $display("FAIL restart_fetch: got %b/%h want 1/0000", coef_bus.CoefReq, coef_bus.CoefAddr); else n_pass++;
    n_checks++; if (mode !== 3'd6) $display("FAIL restart_mode: got %0d want 6", mode); else n_pass++;
    #3 RESET = 1'b1;
    #1;
    n_checks++; if ({coef_bus.CoefReq, Busy} !== 2'b00) $display("FAIL reset_mid_fetch: got req/busy=%b%b want 00", coef_bus.CoefReq, Busy); else n_pass++;
    @(negedge Fg_CLK); RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_ignored();
    test_update();
    test_back_to_back();
    test_timeout();
    test_stop();
    test_reset_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
